// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO pointer control block.
// Holds default geometry and the push/pop grant encoding.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_FIFO_DEPTH = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } grant_e;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer counter with an extra wrap bit.
// Synchronous active-high reset, increment on enable.
module fifo_ptr_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on an accepted access, natural wrap at 2^W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ptr_cnt_top_note.sv
// Thin alias of the wrapping pointer counter so it can be reused
// elsewhere under a descriptive name without touching the pointer block.
module fifo_ptr_cnt_alias #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  fifo_ptr_cnt #(.W(W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc),
    .cnt (cnt)
  );

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Push/pop control for a single-access dual-port FIFO memory.
// Arbitrates contention, owns pointers, flags and sticky errors.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 1 << ADDR_WIDTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  fifo_we,
  output logic                  fifo_rd,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  grant_e grant_q;
  logic   wr_ok;
  logic   rd_ok;
  logic   we_c;
  logic   rd_c;

  assign fifo_cnt     = wptr - rptr;
  assign fifo_empty   = (wptr == rptr);
  // wrap bits differ with equal index <=> distance is a full depth
  assign fifo_full    = (fifo_cnt == DEPTH_C);
  assign almost_full  = (fifo_cnt >= AF_C);
  assign almost_empty = (fifo_cnt <= AE_C);

  assign wr_ok = wr_req & ~fifo_full;
  assign rd_ok = rd_req & ~fifo_empty;

  // single memory access per cycle; toggle decides only on contention
  always_comb begin
    we_c = 1'b0;
    rd_c = 1'b0;
    if (!rstn) begin
      if (wr_ok && rd_ok) begin
        we_c = (grant_q == WR);
        rd_c = (grant_q == RD);
      end else begin
        we_c = wr_ok;
        rd_c = rd_ok;
      end
    end
  end

  assign fifo_we = we_c;
  assign fifo_rd = rd_c;
  assign wr_ack  = we_c;
  assign rd_ack  = rd_c;

  fifo_ptr_cnt #(.W(PW)) u_wptr (
    .clk (clk),
    .rst (rstn),
    .inc (we_c),
    .cnt (wptr)
  );

  fifo_ptr_cnt #(.W(PW)) u_rptr (
    .clk (clk),
    .rst (rstn),
    .inc (rd_c),
    .cnt (rptr)
  );

  // flip grant priority after each contended cycle
  always_ff @(posedge clk) begin
    if (rstn) begin
      grant_q <= WR;
    end else if (wr_ok && rd_ok) begin
      grant_q <= (grant_q == WR) ? RD : WR;
    end
  end

  // read data is valid one cycle after the memory read
  always_ff @(posedge clk) begin
    if (rstn) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_c;
    end
  end

  // sticky errors; a new error beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && fifo_full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_req && fifo_empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl at default geometry.
// Inputs change at negedge; outputs sampled #1 later or at next negedge.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_req;
  logic       rd_req;
  logic       clr_err;
  logic       fifo_we;
  logic       fifo_rd;
  logic [3:0] wptr;
  logic [3:0] rptr;
  logic       wr_ack;
  logic       rd_ack;
  logic       rd_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fifo_cnt;
  logic       overflow;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_w;
  logic [3:0] exp_r;

  fifo_ptr_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .fifo_we      (fifo_we),
    .fifo_rd      (fifo_rd),
    .wptr         (wptr),
    .rptr         (rptr),
    .wr_ack       (wr_ack),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_cnt     (fifo_cnt),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn    = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);

    // enables gated during reset
    wr_req = 1'b1;
    #1;
    chk("rst_we_gate", {31'd0, fifo_we}, 0);
    chk("rst_ack_gate", {31'd0, wr_ack}, 0);
    cyc();
    rstn   = 1'b0;
    wr_req = 1'b0;
    #1;
    chk("idle_empty", {31'd0, fifo_empty}, 1);
    chk("idle_full", {31'd0, fifo_full}, 0);
    chk("idle_cnt", {28'd0, fifo_cnt}, 0);
    chk("idle_ae", {31'd0, almost_empty}, 1);
    chk("idle_af", {31'd0, almost_full}, 0);
    chk("idle_wptr", {28'd0, wptr}, 0);
    chk("idle_rptr", {28'd0, rptr}, 0);
    chk("idle_rd", {31'd0, fifo_rd}, 0);
    chk("idle_rdv", {31'd0, rd_valid}, 0);
    chk("idle_ovf", {31'd0, overflow}, 0);
    cyc();

    // fill 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1;
      #1;
      chk("push_ack", {31'd0, wr_ack}, 1);
      chk("push_wptr", {28'd0, wptr}, i);
      cyc();
      chk("push_cnt", {28'd0, fifo_cnt}, i + 1);
      chk("push_af", {31'd0, almost_full}, (i + 1 >= 7) ? 1 : 0);
      chk("push_full", {31'd0, fifo_full}, (i == 7) ? 1 : 0);
      chk("push_ae", {31'd0, almost_empty}, (i == 0) ? 1 : 0);
    end
    #1;
    chk("ninth_ack", {31'd0, wr_ack}, 0);
    cyc();
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_wptr", {28'd0, wptr}, 4'b1000);
    chk("ovf_cnt", {28'd0, fifo_cnt}, 8);
    wr_req = 1'b0;

    // drain 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1;
      #1;
      chk("pop_ack", {31'd0, rd_ack}, 1);
      chk("pop_rptr", {28'd0, rptr}, i);
      chk("pop_rdv_pre", {31'd0, rd_valid}, (i > 0) ? 1 : 0);
      cyc();
      chk("pop_rdv", {31'd0, rd_valid}, 1);
      chk("pop_cnt", {28'd0, fifo_cnt}, 7 - i);
      chk("pop_empty", {31'd0, fifo_empty}, (i == 7) ? 1 : 0);
    end
    #1;
    chk("udf_ack", {31'd0, rd_ack}, 0);
    cyc();
    chk("udf_set", {31'd0, underflow}, 1);
    chk("udf_rdv", {31'd0, rd_valid}, 0);
    chk("udf_rptr", {28'd0, rptr}, 4'b1000);
    // error set beats clear
    clr_err = 1'b1;
    cyc();
    chk("udf_setwins", {31'd0, underflow}, 1);
    chk("ovf_clr", {31'd0, overflow}, 0);
    rd_req = 1'b0;
    cyc();
    chk("udf_clr", {31'd0, underflow}, 0);
    clr_err = 1'b0;

    // 4 entries then contention
    wr_req = 1'b1;
    repeat (4) cyc();
    chk("pre_cont_cnt", {28'd0, fifo_cnt}, 4);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_we", {31'd0, fifo_we}, (i % 2 == 0) ? 1 : 0);
      chk("cont_rd", {31'd0, fifo_rd}, (i % 2 == 0) ? 0 : 1);
      chk("cont_excl", {31'd0, fifo_we & fifo_rd}, 0);
      cyc();
      chk("cont_cnt", {28'd0, fifo_cnt}, (i % 2 == 0) ? 5 : 4);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("cont_wptr", {28'd0, wptr}, 4'd14);
    chk("cont_rptr", {28'd0, rptr}, 4'd10);

    // wrap-around with alternating push/pop
    exp_w = 4'd14;
    exp_r = 4'd10;
    for (int i = 0; i < 12; i++) begin
      wr_req = 1'b1;
      #1;
      chk("wrap_we", {31'd0, fifo_we}, 1);
      cyc();
      wr_req = 1'b0;
      exp_w  = exp_w + 4'd1;
      chk("wrap_wptr", {28'd0, wptr}, {28'd0, exp_w});
      chk("wrap_cnt5", {28'd0, fifo_cnt}, 5);
      chk("wrap_full", {31'd0, fifo_full}, 0);
      rd_req = 1'b1;
      #1;
      chk("wrap_rd", {31'd0, fifo_rd}, 1);
      cyc();
      rd_req = 1'b0;
      exp_r  = exp_r + 4'd1;
      chk("wrap_rptr", {28'd0, rptr}, {28'd0, exp_r});
      chk("wrap_cnt4", {28'd0, fifo_cnt}, 4);
      chk("wrap_empty", {31'd0, fifo_empty}, 0);
    end

    // full with simultaneous push and pop
    wr_req = 1'b1;
    repeat (4) cyc();
    chk("refill_full", {31'd0, fifo_full}, 1);
    rd_req = 1'b1;
    #1;
    chk("fullboth_we", {31'd0, fifo_we}, 0);
    chk("fullboth_rd", {31'd0, fifo_rd}, 1);
    cyc();
    wr_req = 1'b0;
    chk("fullboth_cnt", {28'd0, fifo_cnt}, 7);
    chk("fullboth_ovf", {31'd0, overflow}, 1);

    // down to 5, then pop with reset right behind it
    repeat (2) cyc();
    chk("pre_rst_cnt", {28'd0, fifo_cnt}, 5);
    cyc();
    chk("inflight_rdv", {31'd0, rd_valid}, 1);
    rd_req = 1'b0;
    wr_req = 1'b1;
    rstn   = 1'b1;
    #1;
    chk("midrst_we", {31'd0, fifo_we}, 0);
    cyc();
    rstn   = 1'b0;
    wr_req = 1'b0;
    chk("midrst_cnt", {28'd0, fifo_cnt}, 0);
    chk("midrst_empty", {31'd0, fifo_empty}, 1);
    chk("midrst_rdv", {31'd0, rd_valid}, 0);
    chk("midrst_ovf", {31'd0, overflow}, 0);
    chk("midrst_udf", {31'd0, underflow}, 0);
    chk("midrst_wptr", {28'd0, wptr}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
- Control end of the FIFO: accepts push/pop requests from client logic.
- Drives write-enable, read-enable, wptr and rptr into the dual-port FIFO memory block.
- Generates full/empty, almost-full/almost-empty, fill-count and sticky error flags.
- Arbitrates between a push and a pop in the same cycle, because the memory performs at most one access per cycle and a write takes priority inside the memory.

Parameters:
- ADDR_WIDTH, 3, memory address bits; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
- FIFO_DEPTH, 1<<ADDR_WIDTH, number of entries.
- AF_THRESH, FIFO_DEPTH-1, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  reset; synchronous, active-high (despite the name).
- wr_req  input  1  client push request.
- rd_req  input  1  client pop request.
- clr_err  input  1  clears the overflow/underflow sticky flags.
- fifo_we  output  1  memory write enable (combinational).
- fifo_rd  output  1  memory read enable (combinational).
- wptr  output  ADDR_WIDTH+1  write pointer (registered).
- rptr  output  ADDR_WIDTH+1  read pointer (registered).
- wr_ack  output  1  push accepted this cycle (equals fifo_we).
- rd_ack  output  1  pop accepted this cycle (equals fifo_rd).
- rd_valid  output  1  memory read data valid; fifo_rd delayed one cycle.
- fifo_full  output  1  FIFO full.
- fifo_empty  output  1  FIFO empty.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- fifo_cnt  output  ADDR_WIDTH+1  occupancy, range 0..FIFO_DEPTH.
- overflow  output  1  sticky: push requested while full.
- underflow  output  1  sticky: pop requested while empty.

Behaviour:
- Reset (rstn=1 at a clk edge):
  - wptr=0, rptr=0, rd_valid=0, overflow=0, underflow=0, grant_toggle=WR.
  - Hence fifo_empty=1, fifo_full=0, fifo_cnt=0, almost_empty=1, almost_full=0.
  - fifo_we, fifo_rd, wr_ack and rd_ack are gated to 0 while rstn=1.
- Flags are combinational from the registered pointers:
  - empty = (wptr==rptr).
  - full = (MSBs differ) and (lower ADDR_WIDTH bits equal).
  - cnt = (wptr-rptr) modulo 2^(ADDR_WIDTH+1).
  - Flags update in the cycle after an accepted access.
- Eligibility:
  - wr_ok = wr_req & ~full.
  - rd_ok = rd_req & ~empty.
- Arbitration:
  - Only one of wr_ok or rd_ok true: grant it.
  - Both true: grant the side selected by grant_toggle, then flip grant_toggle. It flips only on contention.
  - fifo_we and fifo_rd are never both 1.
- Handshake:
  - The client holds a request until its ack; a request that is not acked is not consumed.
  - The memory uses the current wptr/rptr at the same edge.
  - On an accepted access the matching pointer increments by 1 at that edge, wrapping naturally at 2^(ADDR_WIDTH+1).
- Read latency: rd_valid=1 exactly one cycle after fifo_rd=1, otherwise 0.
- Sticky error flags:
  - overflow sets on a cycle with wr_req & full.
  - underflow sets on a cycle with rd_req & empty.
  - clr_err=1 clears both. If clr_err and a new error occur in the same cycle, the set wins.
- Full with simultaneous push and pop: only the pop is eligible; the pop is granted, overflow sets.
- Empty with simultaneous push and pop: only the push is granted, underflow sets. A write never bypasses to the read side.
- Reset mid-operation: all state returns to reset values at the next edge; in-flight rd_valid is dropped.

Decomposition:
- Package fifo_pkg:
  - Default ADDR_WIDTH and the FIFO_DEPTH derivation.
  - Grant enum: WR=0, RD=1.
  - A pointer-width constant.
- One sub-module, fifo_ptr_cnt:
  - (ADDR_WIDTH+1)-bit wrapping counter with synchronous active-high reset and increment enable.
  - Instantiated twice, for wptr and rptr.

Test Plan (ADDR_WIDTH=3, FIFO_DEPTH=8, defaults):
- Reset then idle -> empty=1, full=0, cnt=0, almost_empty=1, wptr=rptr=0, no enables asserted.
- Push 8 entries back-to-back -> wr_ack every cycle; cnt counts 1..8; almost_full=1 at cnt=7; full=1 at cnt=8; wptr=4'b1000. Ninth push -> wr_ack=0, overflow=1, wptr unchanged.
- Pop 8 entries back-to-back from full -> rd_valid follows each rd_ack by one cycle; empty=1 after the 8th pop; rptr=4'b1000. Further pop -> underflow=1; clr_err clears it.
- Hold wr_req=rd_req=1 at cnt=4 for 4 cycles -> grants alternate WR,RD,WR,RD; fifo_we&fifo_rd never both 1; cnt stays 4..5.
- Wrap-around: 12 push/pop pairs in sequence -> pointers pass 4'b1111->4'b0000 without false full/empty; cnt stays correct throughout.
- Assert rstn for one cycle at cnt=5 with a pop in flight -> next cycle cnt=0, empty=1, rd_valid=0, sticky flags=0.
